// File: rtl/cell_bist_pkg.sv
// Shared types and constants for the logic-cell self-test controller.
package cell_bist_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam int OBS_BUF  = 0;
  localparam int OBS_AND  = 1;
  localparam int OBS_OR   = 2;
  localparam int OBS_XOR  = 3;
  localparam int OBS_NAND = 4;
  localparam int OBS_NOT  = 5;
  localparam int OBS_MUX  = 6;
  localparam int OBS_DFF  = 7;

  localparam int NUM_VEC = 8;
  localparam logic [3:0] ERR_SAT = 4'd15;

  function automatic logic [2:0] lowest_set(input logic [7:0] bits);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bits[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/cell_bist_if.sv
// Bundle between the self-test controller and whatever launches it and hosts the cells.
interface cell_bist_if;
  logic       start;
  logic [7:0] cell_mask;
  logic [7:0] obs;
  logic       tv_a;
  logic       tv_b;
  logic       tv_sel;
  logic       tv_d;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [2:0] fail_cell;
  logic [2:0] fail_vec;

  modport master (
    output start, cell_mask, obs,
    input  tv_a, tv_b, tv_sel, tv_d, busy, done, pass, err_cnt, fail_cell, fail_vec
  );

  modport slave (
    input  start, cell_mask, obs,
    output tv_a, tv_b, tv_sel, tv_d, busy, done, pass, err_cnt, fail_cell, fail_vec
  );
endinterface

// File: rtl/cell_bist_golden.sv
// Reference responses of the eight cells under test for the current drive vector.
module cell_bist_golden
  import cell_bist_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       sel,
  input  logic       d,
  output logic [7:0] expected
);

  always_comb begin
    expected           = '0;
    expected[OBS_BUF]  = a;
    expected[OBS_AND]  = a & b;
    expected[OBS_OR]   = a | b;
    expected[OBS_XOR]  = a ^ b;
    expected[OBS_NAND] = ~(a & b);
    expected[OBS_NOT]  = ~a;
    expected[OBS_MUX]  = sel ? b : a;
    expected[OBS_DFF]  = d;
  end

endmodule

// File: rtl/cell_bist_ctrl.sv
// Walks eight test vectors through the cells, two cycles each, and records mismatches.
module cell_bist_ctrl
  import cell_bist_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  cell_bist_if.slave   bus
);

  state_t     state, state_next;
  logic [2:0] v;
  logic [2:0] v_next;
  logic       tv_a, tv_b, tv_sel, tv_d;
  logic [3:0] err_cnt;
  logic [2:0] fail_cell, fail_vec;
  logic [7:0] expected;
  logic [7:0] mism;
  logic       start_run;
  logic       last_vec;

  cell_bist_golden u_golden (
    .a        (tv_a),
    .b        (tv_b),
    .sel      (tv_sel),
    .d        (tv_d),
    .expected (expected)
  );

  assign mism      = (bus.obs ^ expected) & bus.cell_mask;
  assign start_run = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last_vec  = (v == 3'(NUM_VEC - 1));
  assign v_next    = v + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = APPLY;
      APPLY:   state_next = SAMPLE;
      SAMPLE:  state_next = last_vec ? DONE : APPLY;
      DONE:    if (bus.start) state_next = APPLY;
      default: state_next = IDLE;
    endcase
  end

  // err_cnt==0 doubles as the "no mismatch yet this run" flag for fail capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v         <= '0;
      tv_a      <= 1'b0;
      tv_b      <= 1'b0;
      tv_sel    <= 1'b0;
      tv_d      <= 1'b0;
      err_cnt   <= '0;
      fail_cell <= '0;
      fail_vec  <= '0;
    end else if (start_run) begin
      v         <= '0;
      tv_a      <= 1'b0;
      tv_b      <= 1'b0;
      tv_sel    <= 1'b0;
      tv_d      <= 1'b0;
      err_cnt   <= '0;
      fail_cell <= '0;
      fail_vec  <= '0;
    end else if (state == SAMPLE) begin
      if (mism != 8'h00) begin
        if (err_cnt != ERR_SAT) err_cnt <= err_cnt + 4'd1;
        if (err_cnt == 4'd0) begin
          fail_vec  <= v;
          fail_cell <= lowest_set(mism);
        end
      end
      if (!last_vec) begin
        v      <= v_next;
        tv_a   <= v_next[0];
        tv_b   <= v_next[1];
        tv_sel <= v_next[2];
        tv_d   <= v_next[0];
      end
    end
  end

  always_comb begin
    bus.busy      = (state == APPLY) || (state == SAMPLE);
    bus.done      = (state == DONE);
    bus.pass      = (state == DONE) && (err_cnt == 4'd0);
    bus.err_cnt   = err_cnt;
    bus.fail_cell = fail_cell;
    bus.fail_vec  = fail_vec;
    bus.tv_a      = tv_a;
    bus.tv_b      = tv_b;
    bus.tv_sel    = tv_sel;
    bus.tv_d      = tv_d;
  end

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Directed bench: models the real cells around the controller and injects stuck-at faults on obs.
module tb_cell_bist_ctrl;

  logic clk;
  logic rst_n;
  logic [7:0] force_en;
  logic [7:0] force_val;
  logic [7:0] real_obs;
  logic dff_q;
  int tests_run;
  int tests_failed;

  cell_bist_if bus ();

  cell_bist_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial dff_q = 1'b0;
  always @(posedge clk) dff_q <= bus.tv_d;

  assign real_obs = {dff_q, (bus.tv_sel ? bus.tv_b : bus.tv_a), ~bus.tv_a,
                     ~(bus.tv_a & bus.tv_b), bus.tv_a ^ bus.tv_b, bus.tv_a | bus.tv_b,
                     bus.tv_a & bus.tv_b, bus.tv_a};
  assign bus.obs = (real_obs & ~force_en) | (force_val & force_en);

  task automatic start_pulse();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.cell_mask = 8'hFF;
    force_en = 8'h00; force_val = 8'h00;
    #12;
    tests_run++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.pass});
    end
    tests_run++;
    if ({bus.err_cnt, bus.fail_cell, bus.fail_vec} !== 10'd0) begin
      tests_failed++; $display("[TB] FAIL reset_results: got %h expected 0", {bus.err_cnt, bus.fail_cell, bus.fail_vec});
    end
    tests_run++;
    if ({bus.tv_a, bus.tv_b, bus.tv_sel, bus.tv_d} !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL reset_tv: got %b expected 0000", {bus.tv_a, bus.tv_b, bus.tv_sel, bus.tv_d});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL idle_hold: got %b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_clean_run();
    logic [2:0] vexp;
    bus.cell_mask = 8'hFF; force_en = 8'h00;
    start_pulse();
    for (int k = 0; k < 16; k++) begin
      vexp = 3'(k / 2);
      tests_run++;
      if ({bus.busy, bus.tv_a, bus.tv_b, bus.tv_sel, bus.tv_d} !== {1'b1, vexp[0], vexp[1], vexp[2], vexp[0]}) begin
        tests_failed++;
        $display("[TB] FAIL clean_tv cycle %0d: got %b expected %b", k,
                 {bus.busy, bus.tv_a, bus.tv_b, bus.tv_sel, bus.tv_d}, {1'b1, vexp[0], vexp[1], vexp[2], vexp[0]});
      end
      @(negedge clk);
    end
    tests_run++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b011) begin
      tests_failed++; $display("[TB] FAIL clean_done: got %b expected 011", {bus.busy, bus.done, bus.pass});
    end
    tests_run++;
    if ({bus.err_cnt, bus.fail_cell, bus.fail_vec} !== 10'd0) begin
      tests_failed++; $display("[TB] FAIL clean_results: got %h expected 0", {bus.err_cnt, bus.fail_cell, bus.fail_vec});
    end
  endtask

  task automatic test_fault(input string name, input logic [7:0] mask, input logic [7:0] fen,
                            input logic [7:0] fval, input logic [3:0] exp_err,
                            input logic [2:0] exp_cell, input logic [2:0] exp_vec, input logic exp_pass);
    int cycles;
    bit ok;
    bus.cell_mask = mask; force_en = fen; force_val = fval;
    start_pulse();
    wait_done(cycles, ok);
    tests_run++;
    if (!ok || cycles != 16) begin
      tests_failed++; $display("[TB] FAIL %s_latency: got %0d busy cycles (done=%0d) expected 16", name, cycles, ok);
    end
    tests_run++;
    if ({bus.err_cnt, bus.fail_cell, bus.fail_vec, bus.pass} !== {exp_err, exp_cell, exp_vec, exp_pass}) begin
      tests_failed++;
      $display("[TB] FAIL %s_results: got err=%0d cell=%0d vec=%0d pass=%0d expected err=%0d cell=%0d vec=%0d pass=%0d",
               name, bus.err_cnt, bus.fail_cell, bus.fail_vec, bus.pass, exp_err, exp_cell, exp_vec, exp_pass);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.done, bus.err_cnt, bus.fail_cell, bus.fail_vec, bus.pass} !== {1'b1, exp_err, exp_cell, exp_vec, exp_pass}) begin
      tests_failed++; $display("[TB] FAIL %s_hold: results changed while in DONE", name);
    end
  endtask

  task automatic test_reset_mid_run();
    int cycles;
    bit ok;
    bus.cell_mask = 8'hFF; force_en = 8'hFF; force_val = 8'h00;
    start_pulse();
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.fail_cell, bus.fail_vec,
         bus.tv_a, bus.tv_b, bus.tv_sel, bus.tv_d} !== 17'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset: got busy=%0d done=%0d err=%0d cell=%0d vec=%0d tv=%b expected all 0",
               bus.busy, bus.done, bus.err_cnt, bus.fail_cell, bus.fail_vec,
               {bus.tv_a, bus.tv_b, bus.tv_sel, bus.tv_d});
    end
    @(negedge clk) rst_n = 1'b1;
    force_en = 8'h00;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL midrun_idle: got %b expected 00", {bus.busy, bus.done});
    end
    start_pulse();
    wait_done(cycles, ok);
    tests_run++;
    if (!ok || cycles != 16 || bus.pass !== 1'b1 || bus.err_cnt !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_rerun: got cycles=%0d done=%0d pass=%0d err=%0d expected 16 1 1 0",
               cycles, ok, bus.pass, bus.err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    bit ok;
    bus.cell_mask = 8'hFF; force_en = 8'h02; force_val = 8'h02;
    start_pulse();
    cycles = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) cycles++;
      if (k == 5) bus.start = 1'b1;
      if (k == 6) bus.start = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (!ok || cycles != 16 || bus.err_cnt !== 4'd6) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_ignored: got cycles=%0d done=%0d err=%0d expected 16 1 6", cycles, ok, bus.err_cnt);
    end
    force_en = 8'h00;
    start_pulse();
    tests_run++;
    if ({bus.busy, bus.done, bus.err_cnt, bus.fail_cell, bus.fail_vec} !== {2'b10, 10'd0}) begin
      tests_failed++;
      $display("[TB] FAIL restart_clear: got busy=%0d done=%0d err=%0d cell=%0d vec=%0d expected 1 0 0 0 0",
               bus.busy, bus.done, bus.err_cnt, bus.fail_cell, bus.fail_vec);
    end
    wait_done(cycles, ok);
    tests_run++;
    if (!ok || cycles != 16 || bus.pass !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL restart_run: got cycles=%0d done=%0d pass=%0d expected 16 1 1", cycles, ok, bus.pass);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_clean_run();
    test_fault("and_stuck1", 8'hFF, 8'h02, 8'h02, 4'd6, 3'd1, 3'd0, 1'b0);
    test_fault("and_masked", 8'hFD, 8'h02, 8'h02, 4'd0, 3'd0, 3'd0, 1'b1);
    test_fault("all_zero",   8'hFF, 8'hFF, 8'h00, 4'd8, 3'd4, 3'd0, 1'b0);
    test_fault("dff_stuck0", 8'hFF, 8'h80, 8'h00, 4'd4, 3'd7, 3'd1, 1'b0);
    test_fault("mask_none",  8'h00, 8'hFF, 8'h00, 4'd0, 3'd0, 3'd0, 1'b1);
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
